// File: rtl/cobs_pkg.sv
// Shared constants and types for the COBS receive path.
//   COBS_DELIM       frame delimiter byte
//   COBS_MAX_CODE    code byte for a full 254-byte block with no implied zero
//   cobs_dec_state_t decoder FSM: CODE expects a code byte, DATA is inside a block
package cobs_pkg;

  localparam logic [7:0] COBS_DELIM    = 8'h00;
  localparam logic [7:0] COBS_MAX_CODE = 8'hFF;

  typedef enum logic [0:0] {
    CODE = 1'b0,
    DATA = 1'b1
  } cobs_dec_state_t;

endpackage

// File: rtl/cobs_decoder.sv
// Streaming COBS decoder: 0x00-delimited encoded bytes in, decoded AXI-Stream
// frames out, one byte per clock.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   s_tdata/s_tvalid/s_tready   encoded byte input
//   m_tdata/m_tvalid/m_tready   decoded byte output
//   m_tlast                     last byte of a frame
//   m_tuser                     frame malformed (valid with m_tlast only)
//   frame_error                 one-cycle pulse per malformed frame
//   frames_ok, frames_err       saturating frame counters
//   dbg_state                   {in_frame, state} for observation
//
// Handshake: a beat transfers on a rising edge where valid && ready. A source
// holds its payload stable and keeps valid high until that edge.
// s_tready = !m_tvalid || m_tready, so every accepted byte can place at most one
// beat into a free or draining output register.
//
// The newest decoded byte waits in a hold register until the next input byte
// shows whether it ends the frame; only then does it move to the output with
// the correct m_tlast.
module cobs_decoder
  import cobs_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  output logic [7:0]             m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic                   m_tuser,
  output logic                   frame_error,
  output logic [COUNT_WIDTH-1:0] frames_ok,
  output logic [COUNT_WIDTH-1:0] frames_err,
  output logic [1:0]             dbg_state
);

  cobs_dec_state_t state, state_d;
  logic [7:0]      count, count_d;
  logic            pend_zero, pend_zero_d;
  logic            in_frame, in_frame_d;
  logic [7:0]      hold_data;
  logic            hold_valid;

  logic            accept;
  logic            is_delim;
  logic            do_insert;
  logic [7:0]      insert_data;
  logic            do_end;
  logic            end_err;

  assign s_tready  = !m_tvalid || m_tready;
  assign accept    = s_tvalid && s_tready;
  assign is_delim  = (s_tdata == COBS_DELIM);
  assign dbg_state = {in_frame, state};

  // Decode of the accepted byte: what to insert into hold, whether the frame
  // ends, and the next FSM values.
  always_comb begin
    state_d     = state;
    count_d     = count;
    pend_zero_d = pend_zero;
    in_frame_d  = in_frame;
    do_insert   = 1'b0;
    insert_data = COBS_DELIM;
    do_end      = 1'b0;
    end_err     = 1'b0;
    if (accept) begin
      case (state)
        CODE: begin
          if (is_delim) begin
            // The zero implied by the last block is the frame terminator itself.
            do_end      = 1'b1;
            pend_zero_d = 1'b0;
            in_frame_d  = 1'b0;
          end else begin
            do_insert   = pend_zero;
            insert_data = COBS_DELIM;
            count_d     = s_tdata - 8'd1;
            pend_zero_d = (s_tdata != COBS_MAX_CODE);
            in_frame_d  = 1'b1;
            state_d     = (s_tdata > 8'd1) ? DATA : CODE;
          end
        end
        DATA: begin
          if (is_delim) begin
            // Delimiter inside a block: the frame is truncated.
            do_end      = 1'b1;
            end_err     = 1'b1;
            pend_zero_d = 1'b0;
            in_frame_d  = 1'b0;
            count_d     = 8'd0;
            state_d     = CODE;
          end else begin
            do_insert   = 1'b1;
            insert_data = s_tdata;
            count_d     = count - 8'd1;
            if (count == 8'd1) state_d = CODE;
          end
        end
        default: state_d = CODE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= CODE;
      count       <= 8'd0;
      pend_zero   <= 1'b0;
      in_frame    <= 1'b0;
      hold_data   <= 8'd0;
      hold_valid  <= 1'b0;
      m_tdata     <= 8'd0;
      m_tvalid    <= 1'b0;
      m_tlast     <= 1'b0;
      m_tuser     <= 1'b0;
      frame_error <= 1'b0;
      frames_ok   <= '0;
      frames_err  <= '0;
    end else begin
      state       <= state_d;
      count       <= count_d;
      pend_zero   <= pend_zero_d;
      in_frame    <= in_frame_d;
      frame_error <= end_err;

      if (m_tready) m_tvalid <= 1'b0;

      // Insertion pushes the previous held byte out as a non-final beat.
      if (do_insert) begin
        if (hold_valid) begin
          m_tvalid <= 1'b1;
          m_tdata  <= hold_data;
          m_tlast  <= 1'b0;
          m_tuser  <= 1'b0;
        end
        hold_data  <= insert_data;
        hold_valid <= 1'b1;
      end

      // Frame end flushes hold as the final beat; an empty hold emits nothing.
      if (do_end) begin
        if (hold_valid) begin
          m_tvalid   <= 1'b1;
          m_tdata    <= hold_data;
          m_tlast    <= 1'b1;
          m_tuser    <= end_err;
          hold_valid <= 1'b0;
        end
        if (end_err) begin
          if (frames_err != '1) frames_err <= frames_err + 1'b1;
        end else if (hold_valid) begin
          if (frames_ok != '1) frames_ok <= frames_ok + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cobs_decoder.sv
module tb_cobs_decoder;

  logic        clk;
  logic        rst_n;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        m_tuser;
  logic        frame_error;
  logic [15:0] frames_ok;
  logic [15:0] frames_err;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int err_pulses = 0;
  logic ready_toggle = 1'b0;

  // Beats as {tlast, tuser, data}
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];

  logic        prev_stall = 1'b0;
  logic [10:0] prev_beat  = '0;

  cobs_decoder #(.COUNT_WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .m_tuser     (m_tuser),
    .frame_error (frame_error),
    .frames_ok   (frames_ok),
    .frames_err  (frames_err),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_toggle) m_tready = ~m_tready;
      else              m_tready = 1'b1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!s_tready) check_eq("send_timeout", {31'd0, s_tready}, 32'd1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && m_tvalid && m_tready) got_q.push_back({m_tlast, m_tuser, m_tdata});
      if (rst_n && frame_error) err_pulses++;
      if (rst_n && prev_stall)
        check_eq("stall_hold", {21'd0, m_tvalid, m_tlast, m_tuser, m_tdata}, {21'd0, prev_beat});
      if (rst_n && m_tvalid && !m_tready)
        check_eq("s_tready_stall", {31'd0, s_tready}, 32'd0);
      prev_stall = rst_n && m_tvalid && !m_tready;
      prev_beat  = {1'b1, m_tlast, m_tuser, m_tdata};
    end
  end

  // ---------------- scoreboard ----------------
  task automatic exp_beat(input logic [7:0] d, input logic last, input logic user);
    exp_q.push_back({last, user, d});
  endtask

  task automatic check_sb(input string tag);
    int n;
    check_eq({tag, "_beats"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check_eq($sformatf("%s_beat%0d", tag, i), {22'd0, got_q[i]}, {22'd0, exp_q[i]});
  endtask

  task automatic new_scenario();
    do_reset();
    exp_q.delete();
    got_q.delete();
    err_pulses = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    check_eq("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    check_eq("rst_m_tdata", {24'd0, m_tdata}, 32'd0);
    check_eq("rst_m_tlast", {31'd0, m_tlast}, 32'd0);
    check_eq("rst_m_tuser", {31'd0, m_tuser}, 32'd0);
    check_eq("rst_frame_error", {31'd0, frame_error}, 32'd0);
    check_eq("rst_frames_ok", {16'd0, frames_ok}, 32'd0);
    check_eq("rst_frames_err", {16'd0, frames_err}, 32'd0);
    check_eq("rst_s_tready", {31'd0, s_tready}, 32'd1);
    check_eq("rst_dbg_state", {30'd0, dbg_state}, 32'd0);

    // Basic frame: 03 11 22 02 33 00
    new_scenario();
    send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h02); send_byte(8'h33);
    check_eq("basic_pre_delim_valid", {31'd0, m_tvalid}, 32'd1);
    check_eq("basic_pre_delim_tlast", {31'd0, m_tlast}, 32'd0);
    send_byte(8'h00);
    check_eq("basic_last_valid", {31'd0, m_tvalid}, 32'd1);
    check_eq("basic_last_data", {24'd0, m_tdata}, 32'h33);
    check_eq("basic_last_tlast", {31'd0, m_tlast}, 32'd1);
    idle(4);
    exp_beat(8'h11, 0, 0); exp_beat(8'h22, 0, 0); exp_beat(8'h00, 0, 0); exp_beat(8'h33, 1, 0);
    check_sb("basic");
    check_eq("basic_frames_ok", {16'd0, frames_ok}, 32'd1);
    check_eq("basic_frames_err", {16'd0, frames_err}, 32'd0);

    // Single zero byte, then empty frame
    new_scenario();
    send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h00);
    idle(4);
    exp_beat(8'h00, 1, 0);
    check_sb("zero_empty");
    check_eq("zero_empty_frames_ok", {16'd0, frames_ok}, 32'd1);

    // Max block: FF 01..FE 00
    new_scenario();
    send_byte(8'hFF);
    for (int v = 1; v <= 254; v++) begin
      send_byte(8'(v));
      exp_beat(8'(v), (v == 254), 1'b0);
    end
    send_byte(8'h00);
    idle(4);
    check_sb("max_block");
    check_eq("max_block_frames_ok", {16'd0, frames_ok}, 32'd1);

    // Premature delimiter: 04 AA BB 00, then 00 00
    new_scenario();
    send_byte(8'h04); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h00);
    check_eq("premature_frame_error", {31'd0, frame_error}, 32'd1);
    idle(4);
    exp_beat(8'hAA, 0, 0); exp_beat(8'hBB, 1, 1);
    check_sb("premature");
    check_eq("premature_pulses", err_pulses, 32'd1);
    check_eq("premature_frames_err", {16'd0, frames_err}, 32'd1);
    check_eq("premature_frames_ok", {16'd0, frames_ok}, 32'd0);
    send_byte(8'h00); send_byte(8'h00);
    idle(4);
    check_sb("delims_after");
    check_eq("delims_after_pulses", err_pulses, 32'd1);
    check_eq("delims_after_frames_err", {16'd0, frames_err}, 32'd1);
    check_eq("delims_after_frames_ok", {16'd0, frames_ok}, 32'd0);

    // Premature delimiter with nothing held: 05 00
    new_scenario();
    send_byte(8'h05); send_byte(8'h00);
    idle(4);
    check_sb("premature_empty");
    check_eq("premature_empty_pulses", err_pulses, 32'd1);
    check_eq("premature_empty_frames_err", {16'd0, frames_err}, 32'd1);

    // Backpressure: basic frame with m_tready toggling
    new_scenario();
    ready_toggle = 1'b1;
    send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h02); send_byte(8'h33); send_byte(8'h00);
    idle(8);
    ready_toggle = 1'b0;
    idle(3);
    exp_beat(8'h11, 0, 0); exp_beat(8'h22, 0, 0); exp_beat(8'h00, 0, 0); exp_beat(8'h33, 1, 0);
    check_sb("backpressure");
    check_eq("backpressure_frames_ok", {16'd0, frames_ok}, 32'd1);

    // Reset mid-frame: 03 11, reset, then 02 55 00 (counters carried from above)
    exp_q.delete();
    got_q.delete();
    send_byte(8'h03); send_byte(8'h11);
    check_eq("midrst_pre_dbg_state", {30'd0, dbg_state}, 32'h3);
    do_reset();
    check_eq("midrst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    check_eq("midrst_frames_ok", {16'd0, frames_ok}, 32'd0);
    check_eq("midrst_dbg_state", {30'd0, dbg_state}, 32'd0);
    send_byte(8'h02); send_byte(8'h55); send_byte(8'h00);
    idle(4);
    exp_beat(8'h55, 1, 0);
    check_sb("midrst");
    check_eq("midrst_frames_ok_after", {16'd0, frames_ok}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
